// File: rtl/soundgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soundgen_pkg
// Description : Shared constants for the soundgen PWM path: default sample
//               width, frame-length helper and PWM demodulator state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package soundgen_pkg;

  // Default sample width of the PWM DAC / demodulator pair.
  localparam int N_DEFAULT = 8;

  // A PWM frame lasts 2^n clock cycles.
  function automatic int frame_len(input int n);
    return 1 << n;
  endfunction

  localparam int FRAME_LEN = frame_len(N_DEFAULT);

  // Demodulator states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwm_demod_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_demod_if
// Description : Control, PWM input and decoded-sample signals of the PWM
//               demodulator. master = stream source / sample consumer,
//               slave = demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_demod_if
  import soundgen_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic         en;
  logic         pwm_in;
  logic [N-1:0] sample;
  logic         sample_valid;
  logic         period_err;
  logic         locked;

  modport master (
    output en,
    output pwm_in,
    input  sample,
    input  sample_valid,
    input  period_err,
    input  locked
  );

  modport slave (
    input  en,
    input  pwm_in,
    output sample,
    output sample_valid,
    output period_err,
    output locked
  );

endinterface
`default_nettype wire

// File: rtl/sync_rise.sv
`default_nettype none
// ============================================================================
// Module      : sync_rise
// Description : Two-flop synchronizer for an asynchronous input followed by
//               a delay flop, giving the synchronized level and a one-cycle
//               rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s2,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronize d into the clk domain and keep one cycle of history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign s2   = r_s2;
  assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/pwm_demod.sv
`default_nettype none
// ============================================================================
// Module      : pwm_demod
// Description : Recovers the N-bit duty value from a PWM stream whose frame
//               is 2^N clk cycles. Measures high time per frame, checks the
//               frame length and emits one sample per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_demod
  import soundgen_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  pwm_demod_if.slave bus
);

  localparam logic [N:0] c_FRAME_LEN = (N+1)'(frame_len(N));
  localparam logic [N:0] c_ONE       = (N+1)'(1);

  logic         w_s2;
  logic         w_rise;
  logic         w_frame_end;
  logic [N:0]   w_s2_ext;

  logic [1:0]   r_state;
  logic [N:0]   r_period_cnt;
  logic [N:0]   r_high_cnt;
  logic [N-1:0] r_sample;
  logic         r_sample_valid;
  logic         r_period_err;
  logic         r_locked;

  sync_rise u_sync_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pwm_in),
    .s2    (w_s2),
    .rise  (w_rise)
  );

  assign w_frame_end = (r_period_cnt == c_FRAME_LEN);
  assign w_s2_ext    = {{N{1'b0}}, w_s2};

  // Frame tracking FSM: counts period and high time, decides at each rise
  // or full frame whether to emit a sample, flag an error, or re-acquire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_period_cnt   <= '0;
      r_high_cnt     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_period_err   <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_period_err   <= 1'b0;
      if (!bus.en) begin
        // Disable wins over everything, including a coincident rise.
        r_state      <= ST_IDLE;
        r_period_cnt <= '0;
        r_high_cnt   <= '0;
        r_locked     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_ACQUIRE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
          end
          ST_ACQUIRE: begin
            if (w_rise) begin
              // First edge only anchors the frame; the partial frame is dropped.
              r_state      <= ST_TRACK;
              r_period_cnt <= c_ONE;
              r_high_cnt   <= c_ONE;
            end else if (w_frame_end) begin
              // A whole frame with the line held low decodes as duty 0.
              if (r_high_cnt == '0) begin
                r_sample       <= '0;
                r_sample_valid <= 1'b1;
              end
              r_period_cnt <= c_ONE;
              r_high_cnt   <= '0;
            end else begin
              r_period_cnt <= r_period_cnt + c_ONE;
              r_high_cnt   <= r_high_cnt + w_s2_ext;
            end
          end
          ST_TRACK: begin
            if (w_rise) begin
              if (w_frame_end) begin
                r_sample       <= r_high_cnt[N-1:0];
                r_sample_valid <= 1'b1;
                r_locked       <= 1'b1;
              end else begin
                r_period_err <= 1'b1;
                r_locked     <= 1'b0;
              end
              r_period_cnt <= c_ONE;
              r_high_cnt   <= c_ONE;
            end else if (w_frame_end) begin
              // No edge where the next frame should start: either duty 0
              // follows (line low) or the line is stuck high.
              if (!w_s2) begin
                r_sample       <= r_high_cnt[N-1:0];
                r_sample_valid <= 1'b1;
              end else begin
                r_period_err <= 1'b1;
                r_locked     <= 1'b0;
              end
              r_state      <= ST_ACQUIRE;
              r_period_cnt <= c_ONE;
              r_high_cnt   <= '0;
            end else begin
              r_period_cnt <= r_period_cnt + c_ONE;
              r_high_cnt   <= r_high_cnt + w_s2_ext;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.period_err   = r_period_err;
  assign bus.locked       = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_pwm_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_demod
// Description : Scoreboard bench for pwm_demod. Each scenario is a PWM
//               waveform built from frames; a window-scan reference model
//               predicts the ordered stream of sample / error events, which
//               a monitor compares against the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_demod;
  import soundgen_pkg::*;

  localparam int N   = 8;
  localparam int FL  = 256;

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
    logic       lck;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pwm_demod_if #(.N(N)) bus ();

  pwm_demod #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  bit   wave[$];
  ev_t  m_evs[$];
  int   m_idx[$];
  logic [7:0] last_sample = 8'd0;
  ev_t  mon_got;
  ev_t  mon_exp;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the next predicted event.
  always @(negedge clk) begin
    if (!reset && (bus.sample_valid || bus.period_err)) begin
      mon_got.is_err = bus.period_err;
      mon_got.val    = bus.period_err ? 8'd0 : bus.sample;
      mon_got.lck    = bus.locked;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: actual err=%0b sample=%0d locked=%0b required no event",
                 mon_got.is_err, mon_got.val, mon_got.lck);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp || (bus.sample_valid && bus.period_err)) begin
          failures++;
          $display("FAIL event: actual err=%0b sample=%0d locked=%0b valid=%0b required err=%0b sample=%0d locked=%0b",
                   mon_got.is_err, mon_got.val, mon_got.lck, bus.sample_valid,
                   mon_exp.is_err, mon_exp.val, mon_exp.lck);
        end
      end
    end
  end

  function automatic bit rise_at(input int i);
    if (i == 0) return wave[0];
    return wave[i] && !wave[i-1];
  endfunction

  function automatic int high_count(input int s);
    int h = 0;
    for (int i = s; i < s + FL; i++) h += int'(wave[i]);
    return h;
  endfunction

  function automatic ev_t mk(input bit e, input int v, input bit l);
    ev_t x;
    x.is_err = e;
    x.val    = v[7:0];
    x.lck    = l;
    return x;
  endfunction

  // Reference model: scan the waveform window by window. Each window is the
  // FL indices after the current anchor; the first rise in it (or its
  // absence) decides the outcome per the frame-level decoding rules.
  task automatic model_scan();
    int a; int r; int c; bit trk; bit lck;
    a = -1; trk = 0; lck = 0;
    m_evs.delete(); m_idx.delete();
    while (a + FL < wave.size()) begin
      r = -1;
      for (int i = a + 1; i <= a + FL; i++)
        if (r < 0 && rise_at(i)) r = i;
      c = a + FL;
      if (r >= 0) begin
        if (!trk) begin
          trk = 1;
        end else if (r == c) begin
          lck = 1;
          m_evs.push_back(mk(0, high_count(a), 1)); m_idx.push_back(r);
        end else begin
          lck = 0;
          m_evs.push_back(mk(1, 0, 0)); m_idx.push_back(r);
        end
        a = r;
      end else begin
        if (!trk) begin
          if (high_count(a + 1) == 0) begin
            m_evs.push_back(mk(0, 0, lck)); m_idx.push_back(c);
          end
        end else if (!wave[c]) begin
          m_evs.push_back(mk(0, high_count(a), lck)); m_idx.push_back(c);
        end else begin
          lck = 0;
          m_evs.push_back(mk(1, 0, 0)); m_idx.push_back(c);
        end
        trk = 0;
        a = c;
      end
    end
  endtask

  function automatic bit near_event(input int l);
    foreach (m_idx[k])
      if (m_idx[k] >= l - 10 && m_idx[k] <= l + 4) return 1;
    return 0;
  endfunction

  task automatic add_frame(input int len, input int duty);
    for (int i = 0; i < len; i++) wave.push_back(i < duty);
  endtask

  task automatic lead_in();
    wave.delete();
    repeat (3 + $urandom_range(0, 40)) wave.push_back(1'b0);
  endtask

  // Drive the current waveform, then stop it by dropping en or by reset.
  task automatic run_scenario(input string name, input bit use_reset);
    int base; int len;
    base = wave.size();
    repeat (700) wave.push_back(1'b0);
    model_scan();
    len = base + 3;
    while (near_event(len)) len++;
    foreach (m_evs[k]) begin
      if (m_idx[k] <= len - 3) begin
        exp_q.push_back(m_evs[k]);
        if (!m_evs[k].is_err) last_sample = m_evs[k].val;
      end
    end
    @(negedge clk);
    bus.en     = 1'b1;
    bus.pwm_in = wave[0];
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      bus.pwm_in = wave[i];
    end
    @(negedge clk);
    bus.pwm_in = 1'b0;
    bus.en     = 1'b0;
    if (use_reset) begin
      reset = 1'b1;
      #1;
      check({name, "_rst_sample"}, int'(bus.sample), 0);
      check({name, "_rst_valid"},  int'(bus.sample_valid), 0);
      check({name, "_rst_err"},    int'(bus.period_err), 0);
      check({name, "_rst_locked"}, int'(bus.locked), 0);
      last_sample = 8'd0;
      @(negedge clk);
      reset = 1'b0;
    end else begin
      @(negedge clk);
      check({name, "_dis_valid"},  int'(bus.sample_valid), 0);
      check({name, "_dis_err"},    int'(bus.period_err), 0);
      check({name, "_dis_locked"}, int'(bus.locked), 0);
      check({name, "_dis_sample_held"}, int'(bus.sample), int'(last_sample));
    end
    check({name, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int flen;
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sample", int'(bus.sample), 0);
    check("reset_valid",  int'(bus.sample_valid), 0);
    check("reset_err",    int'(bus.period_err), 0);
    check("reset_locked", int'(bus.locked), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    lead_in(); repeat (6) add_frame(FL, 127);
    run_scenario("duty127", 0);

    lead_in(); repeat (4) add_frame(FL, 0);
    run_scenario("duty0", 0);

    lead_in(); repeat (5) add_frame(FL, 255);
    run_scenario("duty255", 1);

    lead_in();
    repeat (3) add_frame(FL, 200);
    repeat (3) add_frame(FL, 0);
    repeat (3) add_frame(FL, 50);
    run_scenario("switch", 0);

    lead_in();
    repeat (3) add_frame(FL, 127);
    add_frame(200, 100);
    repeat (3) add_frame(FL, 127);
    run_scenario("short", 0);

    for (int s = 0; s < 4; s++) begin
      lead_in();
      repeat (7) begin
        flen = ($urandom_range(0, 4) == 0) ? $urandom_range(150, 255) : FL;
        add_frame(flen, $urandom_range(0, flen - 1));
      end
      run_scenario($sformatf("rand%0d", s), s[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
